key_inv_round: RTL and testbench
================================

# key_inv_round

Single-round inverse AES-128 key expansion. It takes round key K(i) as 16 bytes on the byte-serial key bus and returns round key K(i-1) on the same bus. It uses the shared forward S-box through the standard request/response port. It sits in the decryption datapath, walking the schedule backward from the final round key. It mirrors the forward round-key generator byte-for-byte in ordering, handshakes and S-box usage.

## Interface
- SBOX_LAT, 1: cycles from an `enable_sbox`/`addr_out` request to valid `sbox_in`. Legal range 1..3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  8  key byte in; sampled when `enable_din`=1 in LOAD.
- enable_din  in  1  input byte strobe.
- rcon  in  8  round constant of the round that produced K(i); sampled on the 16th accepted byte.
- round_complete  in  1  release pulse; permits output streaming.
- addr_out  out  8  S-box address.
- enable_sbox  out  1  S-box request strobe.
- sbox_in  in  8  S-box result.
- dout  out  8  output key byte.
- enable_out  out  1  output byte strobe.
- busy  out  1  high in every state except LOAD.

## Operation
- Byte order is row-major on both buses: byte k is row k/4, column k%4. Column c (word Wc) is bytes c, c+4, c+8, c+12.
- Math, with inputs W0..W3 and outputs P0..P3:
  - P3 = W3^W2, P2 = W2^W1, P1 = W1^W0.
  - P0 = W0 ^ SubWord(RotWord(P3)) ^ {rcon,00,00,00}.
  - RotWord feeds rows 1,2,3,0 of P3.
- FSM:
  - LOAD: accept bytes into the key buffer on `enable_din`. The 16th byte goes to XOR.
  - XOR: compute P3, P2, P1, one column per cycle (3 cycles). Results go to the output buffer.
  - SUB: issue 4 requests on consecutive cycles, addresses P3 rows 1,2,3,0. Capture the results SBOX_LAT cycles after each request.
  - MIX: one cycle. P0 = W0 ^ sub ^ rcon on row 0.
  - HOLD: wait for `round_complete`=1.
  - SEND: 16 consecutive cycles with `enable_out`=1 and `dout` = byte 0..15. Then return to LOAD.
- `enable_din` outside LOAD is ignored; those bytes are dropped.
- A `round_complete` pulse in any state other than HOLD is ignored. It is not latched.
- `sbox_in` is ignored except at capture cycles.
- All arithmetic is 8-bit XOR. The byte counter is 5 bits and saturates; it never wraps into a new round.

## Timing
- Reset values: `dout`=0, `addr_out`=0, `enable_out`=0, `enable_sbox`=0, `busy`=0, FSM=LOAD, counters=0.
- Reset mid-operation clears FSM and counters immediately. Buffer contents are don't-care and are never emitted.
- Latency from the 16th `din` edge to HOLD is 3 + 4 + SBOX_LAT + 1 cycles (9 at SBOX_LAT=1).
- First `enable_out` is asserted the cycle after `round_complete` is sampled in HOLD.
- `enable_sbox` is high for exactly 4 consecutive cycles per round.
- `enable_out` is high for exactly 16 consecutive cycles per round, with no gaps.
- Back-to-back: LOAD accepts `din` on the cycle after the last SEND byte.

## Configuration
- Macro: KEY_INV_RCON_AUTO_EN.
- Defined:
  - The `rcon` port is ignored. An internal rcon register resets to 0x36.
  - After each completed SEND it steps backward: 0x1B→0x80; 0x01→0x36 (wrap); otherwise x>>1.
- Undefined: rcon is taken from the port as described. No internal register is built.

## Structure
- Shared package: FSM state enum (LOAD, XOR, SUB, MIX, HOLD, SEND), the rotate order constant {1,2,3,0}, and the RCON_LAST=0x36 constant. The forward generator imports the same package.
- One sub-module, `key_rcon_step`: combinational inverse rcon stepping. It is instantiated only under KEY_INV_RCON_AUTO_EN.

## Test plan
- FIPS-197 A.1 round-1 key (w4..w7 = a0fafe17 88542cb1 23a33939 2a6c7605) fed row-major with rcon=0x01, then a `round_complete` pulse:
  - dout = 2b 28 ab 09 7e ae f7 cf 15 d2 15 4f 16 a6 88 3c.
  - Exactly 4 `enable_sbox` cycles.
- Chain 10 rounds from FIPS-197 round-10 key d014f9a8 c9ee2589 e13f0cc8 b6630ca6, with rcon 0x36 down to 0x01:
  - Final output is 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Under KEY_INV_RCON_AUTO_EN, repeat with the `rcon` port tied to 0; the results must be identical.
- `round_complete` pulsed during SUB:
  - No output.
  - FSM stays in HOLD until a later pulse, then emits the correct 16 bytes.
- `rst_n` dropped at SEND byte 7:
  - `enable_out` goes 0 asynchronously.
  - A fresh 16-byte load yields correct output.
- SBOX_LAT=3 with the S-box model returning 0xFF except at the exact capture cycle:
  - Output must match the first scenario.
- `enable_din` toggled during XOR/HOLD:
  - Input bytes are ignored.
  - The next LOAD starts at byte 0.

Source files
------------

// File: rtl/key_inv_round_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_inv_round_pkg : FSM states and constants shared by the forward    |
// | and inverse AES-128 round-key generators.                 Rev 1.0     |
// +----------------------------------------------------------------------+
package key_inv_round_pkg;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_XOR  = 3'd1,
    ST_SUB  = 3'd2,
    ST_MIX  = 3'd3,
    ST_HOLD = 3'd4,
    ST_SEND = 3'd5
  } kstate_e;

  // RotWord source rows, indexed by SubWord result row: {1,2,3,0}.
  localparam logic [3:0][1:0] ROT_ORDER = {2'd0, 2'd3, 2'd2, 2'd1};

  localparam logic [7:0] RCON_LAST = 8'h36;

  function automatic logic [4:0] cnt_inc(input logic [4:0] c);
    return (c == 5'h1F) ? c : c + 5'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_inv_round_rcon_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_rcon_step : combinational backward step of the AES round         |
// | constant (0x1B->0x80, 0x01->0x36, otherwise x>>1).        Rev 1.0     |
// +----------------------------------------------------------------------+
module key_rcon_step
  import key_inv_round_pkg::*;
(
  input  logic [7:0] rcon_i,
  output logic [7:0] rcon_o
);

  always_comb begin
    rcon_o = {1'b0, rcon_i[7:1]};
    if (rcon_i == 8'h1B)
      rcon_o = 8'h80;
    else if (rcon_i == 8'h01)
      rcon_o = RCON_LAST;
  end

endmodule
`default_nettype wire

// File: rtl/key_inv_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_inv_round : one backward step of the AES-128 key schedule,       |
// | K(i) -> K(i-1), byte-serial. Option: KEY_INV_RCON_AUTO_EN.  Rev 1.0   |
// +----------------------------------------------------------------------+
module key_inv_round
  import key_inv_round_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       enable_din,
  input  logic [7:0] rcon,
  input  logic       round_complete,
  output logic [7:0] addr_out,
  output logic       enable_sbox,
  input  logic [7:0] sbox_in,
  output logic [7:0] dout,
  output logic       enable_out,
  output logic       busy
);

  localparam logic [4:0] LAT5 = 5'(SBOX_LAT);

  kstate_e    state_q;
  logic [4:0] cnt_q;
  logic [7:0] kbuf_q [16];
  logic [7:0] rcon_q;
  logic [7:0] dout_q;
  logic [7:0] addr_q;
  logic       en_sbox_q;
  logic       en_out_q;

  logic [1:0] xcol;
  logic [1:0] req_idx;
  logic [7:0] req_addr;
  logic       cap;
  logic [1:0] cap_row;

`ifdef KEY_INV_RCON_AUTO_EN
  logic [7:0] rcon_d;
  logic       unused_rcon;
  key_rcon_step u_rcon_step (.rcon_i(rcon_q), .rcon_o(rcon_d));
  assign unused_rcon = ^rcon;
`endif

  // The buffer is updated in place: P3, P2, P1 each only read columns not yet overwritten.
  assign xcol     = 2'd3 - cnt_q[1:0];
  assign req_idx  = (state_q == ST_XOR) ? 2'd0 : cnt_q[1:0] + 2'd1;
  assign req_addr = kbuf_q[{ROT_ORDER[req_idx], 2'd3}];
  assign cap      = (state_q == ST_SUB) && (cnt_q >= LAT5) && (cnt_q < LAT5 + 5'd4);
  assign cap_row  = 2'(cnt_q - LAT5);

  always_ff @(posedge clk) begin
    case (state_q)
      ST_LOAD: if (enable_din) kbuf_q[cnt_q[3:0]] <= din;
      ST_XOR: begin
        for (int r = 0; r < 4; r++)
          kbuf_q[{2'(r), xcol}] <= kbuf_q[{2'(r), xcol}] ^ kbuf_q[{2'(r), xcol - 2'd1}];
      end
      ST_SUB:  if (cap) kbuf_q[{cap_row, 2'd0}] <= kbuf_q[{cap_row, 2'd0}] ^ sbox_in;
      ST_MIX:  kbuf_q[0] <= kbuf_q[0] ^ rcon_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cnt_q     <= 5'd0;
      dout_q    <= 8'd0;
      addr_q    <= 8'd0;
      en_sbox_q <= 1'b0;
      en_out_q  <= 1'b0;
`ifdef KEY_INV_RCON_AUTO_EN
      rcon_q    <= RCON_LAST;
`else
      rcon_q    <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (enable_din) begin
            if (cnt_q == 5'd15) begin
              state_q <= ST_XOR;
              cnt_q   <= 5'd0;
`ifndef KEY_INV_RCON_AUTO_EN
              rcon_q  <= rcon;
`endif
            end else begin
              cnt_q <= cnt_inc(cnt_q);
            end
          end
        end
        ST_XOR: begin
          // P3 is ready after the first XOR cycle, so request 0 is issued on entry to SUB.
          if (cnt_q == 5'd2) begin
            state_q   <= ST_SUB;
            cnt_q     <= 5'd0;
            en_sbox_q <= 1'b1;
            addr_q    <= req_addr;
          end else begin
            cnt_q <= cnt_inc(cnt_q);
          end
        end
        ST_SUB: begin
          if (cnt_q < 5'd3) begin
            en_sbox_q <= 1'b1;
            addr_q    <= req_addr;
          end else begin
            en_sbox_q <= 1'b0;
            addr_q    <= 8'd0;
          end
          if (cnt_q == LAT5 + 5'd3) begin
            state_q <= ST_MIX;
            cnt_q   <= 5'd0;
          end else begin
            cnt_q <= cnt_inc(cnt_q);
          end
        end
        ST_MIX: state_q <= ST_HOLD;
        ST_HOLD: begin
          if (round_complete) begin
            state_q  <= ST_SEND;
            en_out_q <= 1'b1;
            dout_q   <= kbuf_q[0];
            cnt_q    <= 5'd1;
          end
        end
        ST_SEND: begin
          if (cnt_q == 5'd16) begin
            state_q  <= ST_LOAD;
            cnt_q    <= 5'd0;
            en_out_q <= 1'b0;
            dout_q   <= 8'd0;
`ifdef KEY_INV_RCON_AUTO_EN
            rcon_q   <= rcon_d;
`endif
          end else begin
            dout_q <= kbuf_q[cnt_q[3:0]];
            cnt_q  <= cnt_inc(cnt_q);
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign addr_out    = addr_q;
  assign enable_sbox = en_sbox_q;
  assign dout        = dout_q;
  assign enable_out  = en_out_q;
  assign busy        = (state_q != ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_key_inv_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_inv_round : directed FIPS-197 vectors on SBOX_LAT=1 and       |
// | SBOX_LAT=3 instances side by side.                         Rev 1.0    |
// +----------------------------------------------------------------------+
module tb_key_inv_round;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] A1_IN  = 128'ha088232afa54a36cfe2c397617b13905;
  localparam logic [127:0] K0     = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] K10    = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       enable_din = 1'b0;
  logic [7:0] rcon = 8'd0;
  logic       round_complete = 1'b0;

  logic [7:0] addr1, addr3, dout1, dout3, sbox1, sbox3;
  logic       en_sbox1, en_sbox3, en_out1, en_out3, busy1, busy3;

  logic       p1_en;
  logic [7:0] p1_a;
  logic [2:0] p3_en;
  logic [7:0] p3_a [3];

  int n_checks = 0;
  int n_err = 0;
  int n1, n3, first1, last1, first3, sb_n1, sb_first1, sb_last1, sb_n3, sb_first3, busy_low1;
  logic [127:0] g1, g3, key;
  logic [7:0] rcon_tab [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  always #5 clk = ~clk;

  key_inv_round #(.SBOX_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .enable_din(enable_din), .rcon(rcon),
    .round_complete(round_complete), .addr_out(addr1), .enable_sbox(en_sbox1),
    .sbox_in(sbox1), .dout(dout1), .enable_out(en_out1), .busy(busy1));

  key_inv_round #(.SBOX_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .enable_din(enable_din), .rcon(rcon),
    .round_complete(round_complete), .addr_out(addr3), .enable_sbox(en_sbox3),
    .sbox_in(sbox3), .dout(dout3), .enable_out(en_out3), .busy(busy3));

  // S-box models: valid only exactly SBOX_LAT cycles after a request, 0xFF otherwise.
  always @(posedge clk) begin
    p1_en   <= en_sbox1;
    p1_a    <= addr1;
    p3_en   <= {p3_en[1:0], en_sbox3};
    p3_a[0] <= addr3;
    p3_a[1] <= p3_a[0];
    p3_a[2] <= p3_a[1];
  end
  assign sbox1 = p1_en ? SBOX[p1_a] : 8'hFF;
  assign sbox3 = p3_en[2] ? SBOX[p3_a[2]] : 8'hFF;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge; returns at a negedge with both instances back in LOAD.
  task automatic run_round(input logic [127:0] k, input logic [7:0] rc, input int pa, input int pb,
                           input bit junk, input int rst_at,
                           output logic [127:0] o1, output logic [127:0] o3);
    bit done;
    done = 1'b0;
    o1 = '0; o3 = '0;
    n1 = 0; n3 = 0; first1 = -1; last1 = -1; first3 = -1;
    sb_n1 = 0; sb_first1 = -1; sb_last1 = -1; sb_n3 = 0; sb_first3 = -1; busy_low1 = 0;
    rcon = rc;
    for (int b = 0; b < 16; b++) begin
      if (b > 0) @(negedge clk);
      enable_din = 1'b1;
      din = k[8*(15-b) +: 8];
    end
    @(negedge clk);
    enable_din = 1'b0;
    din = 8'd0;
    round_complete = (pa == 1) || (pb == 1);
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (en_sbox1) begin
        if (sb_first1 < 0) sb_first1 = i;
        sb_last1 = i;
        sb_n1++;
      end
      if (en_sbox3) begin
        if (sb_first3 < 0) sb_first3 = i;
        sb_n3++;
      end
      if (en_out1) begin
        if (n1 < 16) o1[8*(15-n1) +: 8] = dout1;
        if (first1 < 0) first1 = i;
        last1 = i;
        n1++;
      end
      if (en_out3) begin
        if (n3 < 16) o3[8*(15-n3) +: 8] = dout3;
        if (first3 < 0) first3 = i;
        n3++;
      end
      if (!busy1 && n1 < 16) busy_low1++;
      done = (n1 >= 16) && !en_out1 && (n3 >= 16) && !en_out3;
      if (rst_at >= 0 && en_out1 && n1 == rst_at + 1) begin
        rst_n = 1'b0;
        #1;
        check("async rst enable_out1", 128'(en_out1), 128'(0));
        check("async rst enable_out3", 128'(en_out3), 128'(0));
        check("async rst busy1", 128'(busy1), 128'(0));
        done = 1'b1;
      end
      if (done) break;
      round_complete = (pa == i + 1) || (pb == i + 1);
      if (junk) begin
        enable_din = 1'($urandom_range(0, 1));
        din = 8'hAA;
      end
    end
    round_complete = 1'b0;
    enable_din = 1'b0;
    check("round completes in budget", 128'(done), 128'(1));
  endtask

  initial begin
    #2;
    check("reset dout", 128'(dout1), 128'(0));
    check("reset addr_out", 128'(addr1), 128'(0));
    check("reset enable_out", 128'(en_out1), 128'(0));
    check("reset enable_sbox", 128'(en_sbox1), 128'(0));
    check("reset busy", 128'(busy1), 128'(0));
    check("reset busy lat3", 128'(busy3), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

`ifndef KEY_INV_RCON_AUTO_EN
    // FIPS-197 A.1 round-1 key back to the cipher key.
    run_round(A1_IN, 8'h01, 12, -1, 1'b0, -1, g1, g3);
    check("A1 dout lat1", g1, K0);
    check("A1 dout lat3", g3, K0);
    check("A1 sbox count lat1", 128'(sb_n1), 128'(4));
    check("A1 sbox first lat1", 128'(sb_first1), 128'(3));
    check("A1 sbox last lat1", 128'(sb_last1), 128'(6));
    check("A1 sbox count lat3", 128'(sb_n3), 128'(4));
    check("A1 sbox first lat3", 128'(sb_first3), 128'(3));
    check("A1 out count", 128'(n1), 128'(16));
    check("A1 first out", 128'(first1), 128'(12));
    check("A1 last out", 128'(last1), 128'(27));
    check("A1 busy while active", 128'(busy_low1), 128'(0));
    check("A1 busy after send", 128'(busy1), 128'(0));

    // Earliest release: HOLD reached 9 edges after the 16th byte at lat1, 11 at lat3.
    run_round(A1_IN, 8'h01, 10, 12, 1'b0, -1, g1, g3);
    check("edge release lat1", 128'(first1), 128'(10));
    check("edge release lat3", 128'(first3), 128'(12));
    check("edge dout lat1", g1, K0);
    check("edge dout lat3", g3, K0);

    // Pulse during SUB is not latched.
    run_round(A1_IN, 8'h01, 5, 40, 1'b0, -1, g1, g3);
    check("SUB pulse first lat1", 128'(first1), 128'(40));
    check("SUB pulse first lat3", 128'(first3), 128'(40));
    check("SUB pulse dout lat1", g1, K0);
    check("SUB pulse dout lat3", g3, K0);

    // Stray enable_din while busy is dropped; the following load starts at byte 0.
    run_round(A1_IN, 8'h01, 12, -1, 1'b1, -1, g1, g3);
    check("junk din dout lat1", g1, K0);
    check("junk din dout lat3", g3, K0);
    run_round(A1_IN, 8'h01, 12, -1, 1'b0, -1, g1, g3);
    check("after junk dout lat1", g1, K0);
    check("after junk dout lat3", g3, K0);

    // Reset mid-SEND, then a fresh round.
    run_round(A1_IN, 8'h01, 12, -1, 1'b0, 7, g1, g3);
    #1;
    rst_n = 1'b1;
    run_round(A1_IN, 8'h01, 12, -1, 1'b0, -1, g1, g3);
    check("post reset dout lat1", g1, K0);
    check("post reset dout lat3", g3, K0);
    check("post reset out count", 128'(n1), 128'(16));

    key = K10;
    for (int r = 0; r < 10; r++) begin
      run_round(key, rcon_tab[r], 12, -1, 1'b0, -1, g1, g3);
      key = g1;
    end
    check("chain final lat1", g1, K0);
    check("chain final lat3", g3, K0);
`else
    for (int pass = 0; pass < 2; pass++) begin
      key = K10;
      for (int r = 0; r < 10; r++) begin
        run_round(key, 8'h00, 12, -1, 1'b0, -1, g1, g3);
        key = g1;
      end
      check("auto chain final lat1", g1, K0);
      check("auto chain final lat3", g3, K0);
      check("auto chain out count", 128'(n1), 128'(16));
      check("auto chain sbox count", 128'(sb_n1), 128'(4));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
